// File: rtl/seg_scan_ctrl.sv
// Eight-digit seven-segment scan controller with per-frame shadowed inputs.
// Define SEG_SCAN_LZB_EN to blank leading-zero digits (digit 0 always shown).
module seg_scan_ctrl #(
  parameter int CLK_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dp,
  output logic [2:0]  scan_sel,
  output logic [6:0]  seg,
  output logic        seg_dp,
  output logic        scan_tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    sel_q, sel_d;
  logic          tick_q, tick_d;
  logic [6:0]    seg_q, seg_d;
  logic          seg_dp_q, seg_dp_d;
  logic          load_pend_q, load_pend_d;
  logic [31:0]   data_sh_q, data_sh_d;
  logic [7:0]    digit_en_sh_q, digit_en_sh_d;
  logic [7:0]    dp_sh_q, dp_sh_d;
  logic [7:0]    lz_blank;
  logic          slot_end;
  logic [3:0]    nib;
  logic          show;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Prescaler, digit index and shadow update
  always_comb begin
    cnt_d         = cnt_q;
    sel_d         = sel_q;
    load_pend_d   = load_pend_q;
    data_sh_d     = data_sh_q;
    digit_en_sh_d = digit_en_sh_q;
    dp_sh_d       = dp_sh_q;
    slot_end      = (cnt_q == CNT_MAX);
    if (slot_end) begin
      cnt_d = '0;
      sel_d = sel_q + 3'd1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    // Loading at the 7->0 advance lets digit 0 of the new frame see the new values
    if (load_pend_q || (slot_end && sel_q == 3'd7)) begin
      data_sh_d     = data;
      digit_en_sh_d = digit_en;
      dp_sh_d       = dp;
      load_pend_d   = 1'b0;
    end
    tick_d = (cnt_d == CNT_MAX);
  end

`ifdef SEG_SCAN_LZB_EN
  assign lz_blank[0] = 1'b0;
  for (genvar gi = 1; gi < 8; gi++) begin : g_lzb
    assign lz_blank[gi] = (data_sh_d[31:4*gi] == '0);
  end
`else
  assign lz_blank = '0;
`endif

  // Output pattern follows the next-state index so it switches together with scan_sel
  always_comb begin
    nib      = data_sh_d[{sel_d, 2'b00} +: 4];
    show     = digit_en_sh_d[sel_d] & ~lz_blank[sel_d];
    seg_d    = show ? hex7(nib) : 7'h00;
    seg_dp_d = show & dp_sh_d[sel_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      sel_q         <= '0;
      tick_q        <= 1'b0;
      seg_q         <= '0;
      seg_dp_q      <= 1'b0;
      load_pend_q   <= 1'b1;
      data_sh_q     <= '0;
      digit_en_sh_q <= '0;
      dp_sh_q       <= '0;
    end else begin
      cnt_q         <= cnt_d;
      sel_q         <= sel_d;
      tick_q        <= tick_d;
      seg_q         <= seg_d;
      seg_dp_q      <= seg_dp_d;
      load_pend_q   <= load_pend_d;
      data_sh_q     <= data_sh_d;
      digit_en_sh_q <= digit_en_sh_d;
      dp_sh_q       <= dp_sh_d;
    end
  end

  assign scan_sel  = sel_q;
  assign seg       = seg_q;
  assign seg_dp    = seg_dp_q;
  assign scan_tick = tick_q;

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for an 8-digit seven-segment display. Holds eight hex nibbles, steps a 3-bit digit index at a programmable rate, and drives the segment pattern for the digit currently selected. The block sits directly upstream of the 3-to-8 digit-select decoder: `scan_sel` feeds the decoder input, and `seg`/`seg_dp` drive the shared segment lines.

## Interface
- `CLK_DIV`, default 100000: clock cycles per digit slot; legal range ≥ 2. At 100 MHz the default gives 1 kHz per digit and 125 Hz per frame.
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `data` input 32: digit k value = `data[4k+3:4k]`, k = 0..7.
- `digit_en` input 8: bit k = 1 enables digit k; a disabled digit is blanked.
- `dp` input 8: bit k = decimal point for digit k.
- `scan_sel` output 3: index of the active digit, to the 3-to-8 decoder.
- `seg` output 7: segment pattern, active-high, bit order {g,f,e,d,c,b,a}.
- `seg_dp` output 1: decimal point for the active digit, active-high.
- `scan_tick` output 1: one-cycle pulse on the cycle before each digit advance.

## Operation
- Prescaler `cnt` counts 0..CLK_DIV-1 and wraps to 0.
- `scan_tick` = 1 exactly when `cnt == CLK_DIV-1`. It is a registered output and is aligned with that `cnt` value.
- On a tick cycle edge: `scan_sel <= scan_sel + 1`, wrapping 7 → 0.
- Shadow registers hold `data`, `digit_en` and `dp` so a frame never tears.
  - They load on the tick edge where `scan_sel == 7`, i.e. the frame boundary.
  - They also load on the first edge after `rst` deasserts. A `load_pend` flag is set by reset and cleared by that load.
- Input changes mid-frame have no visible effect until the next load.
- Segment decode from the shadow nibble (gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Digit k is blanked (`seg = 0`, `seg_dp = 0`) when shadow `digit_en[k] = 0`.
- `seg` and `seg_dp` are registered. They always correspond to the current `scan_sel`: they are computed from the next-state index and next-state shadow, so they change on the same edge as `scan_sel`.

## Timing
- Reset values: `cnt = 0`, `scan_sel = 0`, `seg = 7'h00`, `seg_dp = 0`, `scan_tick = 0`, shadows = 0, `load_pend = 1`.
- First edge after reset: shadows load, and `seg`/`seg_dp` show digit 0 from the freshly loaded values. Latency from `rst` low to valid digit 0 is 1 cycle.
- Each digit is displayed for exactly CLK_DIV cycles. A full frame is 8·CLK_DIV cycles.
- `rst` asserted mid-frame: on the next edge every register returns to its reset value. No partial slot completes.
- `rst` held high: outputs stay at their reset values; `scan_tick` never pulses.
- A frame-boundary load and a digit advance on the same edge are one event. Digit 0 of the new frame uses the new shadow values.

## Configuration
- `SEG_SCAN_LZB_EN` defined: leading-zero blanking is enabled.
  - Digit k (k ≥ 1) is blanked when shadow `data[31:4k] == 0`, even if `digit_en[k] = 1`. Its `seg_dp` follows the same rule.
  - Digit 0 is never suppressed by this rule.
- Undefined: every enabled digit shows its nibble, including leading zeros.

## Test plan
- Run with CLK_DIV=4, `data = 32'h76543210`, `digit_en = 8'hFF`, `dp = 0`:
  - `scan_sel` steps 0..7 every 4 cycles, then wraps to 0.
  - `seg` sequence is 3F, 06, 5B, 4F, 66, 6D, 7D, 07.
  - `scan_tick` is high one cycle in four.
- Run with `data = 32'hFEDCBA98`, `dp = 8'h81`:
  - `seg` sequence is 7F, 6F, 77, 7C, 39, 5E, 79, 71.
  - `seg_dp` = 1 only on digits 0 and 7.
- Change `data` while `scan_sel = 3`:
  - Digits 4–7 still show the old values.
  - New values appear from the next `scan_sel = 0`.
- Run with `digit_en = 8'h0F`: digits 4–7 output `seg = 00`, `seg_dp = 0`.
- Assert `rst` for 1 cycle while `scan_sel = 5` and `cnt = 2`:
  - The next cycle shows `scan_sel = 0`, `scan_tick = 0`.
  - The following cycle shows valid digit 0.
  - The next advance occurs after exactly CLK_DIV cycles.
- With `SEG_SCAN_LZB_EN` defined and `data = 32'h00000405`:
  - Digits 3–7 are blank.
  - Digits 0–2 show 6D, 3F, 66.
  - With `data = 0`, only digit 0 shows 3F.
